// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Plays a stored list of (LED pattern, duration in ms) steps on the 8 board
//   LEDs. It is paced by the system 1 ms tick. Steps are written through a
//   valid/ready port while idle, and they are kept across playbacks.
//
// Build option:
//   LED_SEQ_LOOP_EN - when this macro is defined, playback wraps from the last
//   step to step 0 and runs until iStop or rst. oDone is then never asserted.
//   When the macro is undefined, playback is one-shot and oDone pulses at the
//   natural end of the sequence.
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   iTick1ms   one-cycle pulse once per millisecond
//   iWrValid / iWrData / iWrDur / oWrReady   step-write handshake (IDLE only)
//   iClear     empties the step list (IDLE only); wins over a write in the same cycle
//   iStart     begins playback when at least one step is stored
//   iStop      aborts playback; wins over iStart and over a completing tick
//   oLed       active-high LED pattern (0 when idle)
//   oBusy      high while playing
//   oDone      one-cycle pulse at the natural end of the sequence
//   oStep      index of the step being shown
//   oCount     number of stored steps
module led_pattern_sequencer #(
  parameter int DEPTH = 8,
  parameter int DUR_W = 10,
  localparam int SW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iTick1ms,
  input  logic             iWrValid,
  input  logic [7:0]       iWrData,
  input  logic [DUR_W-1:0] iWrDur,
  output logic             oWrReady,
  input  logic             iClear,
  input  logic             iStart,
  input  logic             iStop,
  output logic [7:0]       oLed,
  output logic             oBusy,
  output logic             oDone,
  output logic [SW-1:0]    oStep,
  output logic [SW:0]      oCount
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  localparam logic [SW:0] DEPTH_C   = (SW+1)'(DEPTH);
  localparam logic [SW:0] COUNT_ONE = {{SW{1'b0}}, 1'b1};

  // Step memory (no reset: the contents are meaningless until they are written)
  logic [7:0]       r_pat [DEPTH];
  logic [DUR_W-1:0] r_dur [DEPTH];

  state_t           r_state, w_state_n;
  logic [7:0]       r_led, w_led_n;
  logic             r_busy, w_busy_n;
  logic             r_done, w_done_n;
  logic [SW-1:0]    r_step, w_step_n;
  logic [SW:0]      r_count, w_count_n;
  logic [DUR_W-1:0] r_ms, w_ms_n;
  logic             r_wr_ready, w_wr_ready_n;
  logic             w_mem_we;

  logic             w_wr_fire;
  logic             w_last;
  logic [SW:0]      w_step_inc;
  logic [DUR_W-1:0] w_dur_eff;
  logic [DUR_W:0]   w_ms_inc;

  // r_wr_ready is only ever high in IDLE, so this term is also the accept condition.
  assign w_wr_fire  = iWrValid & r_wr_ready;
  assign w_last     = ({1'b0, r_step} == (r_count - COUNT_ONE));
  assign w_step_inc = {1'b0, r_step} + COUNT_ONE;
  // A stored duration of 0 is played as 1 ms.
  assign w_dur_eff  = (r_dur[r_step] == {DUR_W{1'b0}}) ? {{(DUR_W-1){1'b0}}, 1'b1}
                                                       : r_dur[r_step];
  assign w_ms_inc   = {1'b0, r_ms} + {{DUR_W{1'b0}}, 1'b1};

  // Next-state and next-output logic for the IDLE/PLAY sequencer
  always_comb begin
    w_state_n    = r_state;
    w_led_n      = r_led;
    w_busy_n     = r_busy;
    w_done_n     = 1'b0;
    w_step_n     = r_step;
    w_count_n    = r_count;
    w_ms_n       = r_ms;
    w_wr_ready_n = r_wr_ready;
    w_mem_we     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (iClear) begin
          w_count_n = {(SW+1){1'b0}};
        end else if (w_wr_fire) begin
          w_mem_we  = 1'b1;
          w_count_n = r_count + COUNT_ONE;
        end else begin
          w_count_n = r_count;
        end

        // Stop masks start. A clear in the same cycle empties the list, so it masks start too.
        if (iStart && !iStop && !iClear && (r_count != {(SW+1){1'b0}})) begin
          w_state_n    = ST_PLAY;
          w_busy_n     = 1'b1;
          w_step_n     = {SW{1'b0}};
          w_ms_n       = {DUR_W{1'b0}};
          w_led_n      = r_pat[0];
          w_wr_ready_n = 1'b0;
        end else begin
          w_wr_ready_n = (w_count_n < DEPTH_C);
        end
      end

      ST_PLAY: begin
        if (iStop) begin
          w_state_n    = ST_IDLE;
          w_led_n      = 8'h00;
          w_busy_n     = 1'b0;
          w_step_n     = {SW{1'b0}};
          w_ms_n       = {DUR_W{1'b0}};
          w_wr_ready_n = (r_count < DEPTH_C);
        end else if (iTick1ms) begin
          if (w_ms_inc >= {1'b0, w_dur_eff}) begin
            w_ms_n = {DUR_W{1'b0}};
            if (w_last) begin
`ifdef LED_SEQ_LOOP_EN
              w_step_n = {SW{1'b0}};
              w_led_n  = r_pat[0];
`else
              w_state_n    = ST_IDLE;
              w_led_n      = 8'h00;
              w_busy_n     = 1'b0;
              w_step_n     = {SW{1'b0}};
              w_done_n     = 1'b1;
              w_wr_ready_n = (r_count < DEPTH_C);
`endif
            end else begin
              w_step_n = w_step_inc[SW-1:0];
              w_led_n  = r_pat[w_step_inc[SW-1:0]];
            end
          end else begin
            w_ms_n = w_ms_inc[DUR_W-1:0];
          end
        end else begin
          w_ms_n = r_ms;
        end
      end

      default: begin
        w_state_n    = ST_IDLE;
        w_led_n      = 8'h00;
        w_busy_n     = 1'b0;
        w_step_n     = {SW{1'b0}};
        w_ms_n       = {DUR_W{1'b0}};
        w_wr_ready_n = (r_count < DEPTH_C);
      end
    endcase
  end

  // State and registered-output update, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_led      <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_step     <= {SW{1'b0}};
      r_count    <= {(SW+1){1'b0}};
      r_ms       <= {DUR_W{1'b0}};
      r_wr_ready <= 1'b1;
    end else begin
      r_state    <= w_state_n;
      r_led      <= w_led_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_step     <= w_step_n;
      r_count    <= w_count_n;
      r_ms       <= w_ms_n;
      r_wr_ready <= w_wr_ready_n;
    end
  end

  // Step memory write. A write is only enabled while r_count < DEPTH, so the index is in range.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_pat[r_count[SW-1:0]] <= iWrData;
      r_dur[r_count[SW-1:0]] <= iWrDur;
    end
  end

  assign oLed     = r_led;
  assign oBusy    = r_busy;
  assign oDone    = r_done;
  assign oStep    = r_step;
  assign oCount   = r_count;
  assign oWrReady = r_wr_ready;

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Programmable LED pattern sequencer for the 8-LED board output. It stores up to DEPTH steps, each an 8-bit LED pattern with a duration in milliseconds. On a start request it plays the steps in order, paced by the system 1 ms tick. It sits between the tick generator and the top-level LED pins, replacing the fixed blinker when a scripted sequence is wanted. The top level inverts oLed for the active-low pins.

## Interface
Parameters:
- DEPTH, 8: number of step slots (power of two, 2..64)
- DUR_W, 10: width of the per-step duration field (ms)

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  asynchronous, active-high reset
- iTick1ms  input  1  single-cycle pulse, once per ms
- iWrValid  input  1  step-write request
- iWrData  input  8  LED pattern for the step being written
- iWrDur  input  DUR_W  step duration in ms
- oWrReady  output  1  write accepted this cycle when iWrValid and oWrReady are both high
- iClear  input  1  empties the step memory (IDLE only)
- iStart  input  1  begin playback (level or pulse; sampled per cycle)
- iStop  input  1  abort playback
- oLed  output  8  active-high LED pattern
- oBusy  output  1  high in PLAY
- oDone  output  1  one-cycle pulse at natural end of sequence
- oStep  output  log2(DEPTH)  index of the step being shown
- oCount  output  log2(DEPTH)+1  number of stored steps

## Operation
- Reset values: state IDLE, oLed=0, oBusy=0, oDone=0, oStep=0, oCount=0, oWrReady=1. Memory contents are don't-care.
- State machine: IDLE, PLAY.
- IDLE:
  - oWrReady = (oCount < DEPTH).
  - On a write handshake, store {iWrData, iWrDur} at slot oCount, then oCount+1.
  - iClear sets oCount=0. If iClear and a write occur in the same cycle, clear wins and the write is dropped.
  - iStart with oCount>0 enters PLAY: oStep=0, ms counter=0.
  - iStart with oCount=0 is ignored.
  - iStop has no effect.
- PLAY:
  - oWrReady=0. iClear and iStart are ignored.
  - oLed = pattern[oStep].
  - Each iTick1ms increments the ms counter. On the tick where counter+1 ≥ max(dur[oStep],1), the counter clears and the step advances. A duration of 0 is treated as 1 ms.
  - Advance from the last step (oCount−1): go to IDLE, oLed=0, oStep=0, oDone pulses.
  - iStop: go to IDLE next cycle, oLed=0, oStep=0, no oDone.
  - iStop together with a completing tick: stop wins and oDone stays 0.
  - iStart together with iStop in IDLE: stop wins and no playback starts.
- Stored steps persist across playbacks. A sequence can be replayed without reloading.
- The ms counter is DUR_W bits wide and never wraps, because it clears at the step duration.
- Reset mid-playback: immediate return to reset values. oCount also clears, so memory must be reloaded.

## Timing
- All outputs are registered.
- iStart sampled at edge N: oBusy=1, oStep=0, oLed=pattern[0] visible after edge N (cycle N+1).
- Step change: the new oStep/oLed is visible the cycle after the completing tick.
- A step lasts exactly dur ticks. The first tick counted is the first tick sampled after PLAY is entered.
- End of sequence: oBusy=0, oLed=0 and oDone=1 in the same cycle. oDone=0 in the following cycle.
- Write handshake: oCount updates the cycle after acceptance, and oWrReady drops in that same cycle when memory becomes full.
- Stop latency: 1 cycle.

## Configuration
- LED_SEQ_LOOP_EN defined:
  - Advance from the last step wraps to step 0 and playback continues.
  - oDone is never asserted.
  - PLAY exits only via iStop or rst.
- LED_SEQ_LOOP_EN undefined: one-shot behaviour as described under Operation.

## Test plan
- Reset, then write 3 steps (0x01/2, 0x03/1, 0xFF/3) and start. Required: oLed is 0x01 for 2 ticks, then 0x03 for 1 tick, then 0xFF for 3 ticks; oDone pulses once; oLed=0; oBusy=0; oCount stays 3.
- Write DEPTH+1 times. Required: oWrReady=0 after the DEPTH-th accept, oCount=DEPTH, and the extra write is not stored. Then iClear: oCount=0, oWrReady=1.
- Step with dur=0 (pattern 0xAA). Required: it lasts exactly 1 tick.
- Start with oCount=0. Required: oBusy stays 0. Start with 2 steps loaded, then iStop mid-step 1. Required: oLed=0 next cycle, no oDone, and a following replay starts at step 0.
- iStop asserted on the same cycle as the final completing tick. Required: oDone=0 and state IDLE. Simultaneous iStart and iStop in IDLE: no playback.
- With LED_SEQ_LOOP_EN, 2 steps (0x0F/1, 0xF0/1). Required: alternating patterns for ≥6 ticks, oStep wraps 1→0, and oDone is never high. Assert rst mid-play: all outputs return to reset values asynchronously.
